// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: light bus and monitor status outputs
interface traffic_light_monitor_if #(
  parameter int DW_W  = 8,
  parameter int CNT_W = 16
);
  logic [2:0]       light;
  logic [1:0]       phase;
  logic [DW_W-1:0]  dwell;
  logic             err_valid;
  logic [2:0]       err_code;
  logic             err_sticky;
  logic [CNT_W-1:0] cycle_count;
  modport master (output light, input phase, dwell, err_valid, err_code, err_sticky, cycle_count);
  modport slave  (input light, output phase, dwell, err_valid, err_code, err_sticky, cycle_count);
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of light encoding, phase order and dwell
module traffic_light_monitor #(
  parameter int RED_CYC    = 10,
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int DW_W       = 8,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic reset,
  traffic_light_monitor_if.slave bus
);
  typedef enum logic [1:0] {SYNC, RED, GREEN, YELLOW} phase_t;
  localparam logic [2:0] E_NONE = 3'd0, E_ILL = 3'd1, E_SEQ = 3'd2, E_SHORT = 3'd3, E_LONG = 3'd4;
  localparam logic [DW_W-1:0] RED_D = DW_W'(RED_CYC), GREEN_D = DW_W'(GREEN_CYC), YELLOW_D = DW_W'(YELLOW_CYC);
  localparam logic [DW_W-1:0] DW_MAX = '1;
  phase_t           phase, phase_n, new_ph, next_ph;
  logic [DW_W-1:0]  dwell, dwell_n, req;
  logic             partial, partial_n, in_ill, in_ill_n, legal;
  logic             err_valid, err_sticky, err_sticky_n;
  logic [2:0]       err_code, err_code_n, err;
  logic [CNT_W-1:0] cycle_count, cycle_count_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase       <= SYNC;
      dwell       <= '0;
      partial     <= 1'b0;
      in_ill      <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= E_NONE;
      err_sticky  <= 1'b0;
      cycle_count <= '0;
    end else begin
      phase       <= phase_n;
      dwell       <= dwell_n;
      partial     <= partial_n;
      in_ill      <= in_ill_n;
      err_valid   <= err != E_NONE;
      err_code    <= err_code_n;
      err_sticky  <= err_sticky_n;
      cycle_count <= cycle_count_n;
    end
  always_comb begin
    legal         = bus.light == 3'b100 || bus.light == 3'b010 || bus.light == 3'b001;
    new_ph        = bus.light == 3'b100 ? RED : bus.light == 3'b001 ? GREEN : YELLOW;
    next_ph       = phase == RED ? GREEN : phase == GREEN ? YELLOW : RED;
    req           = phase == RED ? RED_D : phase == GREEN ? GREEN_D : YELLOW_D;
    phase_n       = phase;
    dwell_n       = dwell;
    partial_n     = partial;
    in_ill_n      = 1'b0;
    cycle_count_n = cycle_count;
    err           = E_NONE;
    if (!legal) begin
      phase_n   = SYNC;
      dwell_n   = '0;
      partial_n = 1'b0;
      in_ill_n  = 1'b1;
      err       = in_ill ? E_NONE : E_ILL;
    end else if (phase == SYNC) begin
      phase_n   = new_ph;
      dwell_n   = DW_W'(1);
      partial_n = 1'b1;
    end else if (new_ph == phase) begin
      dwell_n = dwell == DW_MAX ? DW_MAX : dwell + 1'b1;
      err     = dwell == req ? E_LONG : E_NONE;
    end else begin
      phase_n   = new_ph;
      dwell_n   = DW_W'(1);
      partial_n = 1'b0;
      if (new_ph != next_ph) err = E_SEQ;
      else begin
        err           = (!partial && dwell < req) ? E_SHORT : E_NONE;
        cycle_count_n = phase == YELLOW ? cycle_count + 1'b1 : cycle_count;
      end
    end
    err_code_n   = err != E_NONE ? err : err_code;
    err_sticky_n = err_sticky || err != E_NONE;
  end
  assign bus.phase       = phase;
  assign bus.dwell       = dwell;
  assign bus.err_valid   = err_valid;
  assign bus.err_code    = err_code;
  assign bus.err_sticky  = err_sticky;
  assign bus.cycle_count = cycle_count;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed checks of the light monitor with short dwell params
module tb_traffic_light_monitor;
  localparam logic [2:0] R = 3'b100, G = 3'b001, Y = 3'b010;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cmp = 0;
  int mis = 0;
  traffic_light_monitor_if #(.DW_W(8), .CNT_W(16)) bus ();
  traffic_light_monitor #(.RED_CYC(4), .GREEN_CYC(3), .YELLOW_CYC(2), .DW_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int ph, input int dw, input int ev, input int ec, input int es, input int cc);
    chk({tag, " phase"}, 32'(bus.phase), ph);
    chk({tag, " dwell"}, 32'(bus.dwell), dw);
    chk({tag, " err_valid"}, 32'(bus.err_valid), ev);
    chk({tag, " err_code"}, 32'(bus.err_code), ec);
    chk({tag, " err_sticky"}, 32'(bus.err_sticky), es);
    chk({tag, " cycle_count"}, 32'(bus.cycle_count), cc);
  endtask
  task automatic st(input string tag, input logic [2:0] l, input int ph, input int dw, input int ev, input int ec, input int es, input int cc);
    bus.light = l;
    @(posedge clk);
    #1;
    chk_all(tag, ph, dw, ev, ec, es, cc);
  endtask
  initial begin
    bus.light = R;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    // clean full cycle
    st("t1 r1", R, 1, 1, 0, 0, 0, 0);
    st("t1 r2", R, 1, 2, 0, 0, 0, 0);
    st("t1 r3", R, 1, 3, 0, 0, 0, 0);
    st("t1 r4", R, 1, 4, 0, 0, 0, 0);
    st("t1 g1", G, 2, 1, 0, 0, 0, 0);
    st("t1 g2", G, 2, 2, 0, 0, 0, 0);
    st("t1 g3", G, 2, 3, 0, 0, 0, 0);
    st("t1 y1", Y, 3, 1, 0, 0, 0, 0);
    st("t1 y2", Y, 3, 2, 0, 0, 0, 0);
    st("t1 r1b", R, 1, 1, 0, 0, 0, 1);
    st("t1 r2b", R, 1, 2, 0, 0, 0, 1);
    st("t1 r3b", R, 1, 3, 0, 0, 0, 1);
    st("t1 r4b", R, 1, 4, 0, 0, 0, 1);
    // short green
    st("t2 g1", G, 2, 1, 0, 0, 0, 1);
    st("t2 g2", G, 2, 2, 0, 0, 0, 1);
    st("t2 y1", Y, 3, 1, 1, 3, 1, 1);
    st("t2 y2", Y, 3, 2, 0, 3, 1, 1);
    st("t2 r1", R, 1, 1, 0, 3, 1, 2);
    // red straight to yellow
    st("t3 r2", R, 1, 2, 0, 3, 1, 2);
    st("t3 r3", R, 1, 3, 0, 3, 1, 2);
    st("t3 r4", R, 1, 4, 0, 3, 1, 2);
    st("t3 y1", Y, 3, 1, 1, 2, 1, 2);
    st("t3 y2", Y, 3, 2, 0, 2, 1, 2);
    st("t3 r1", R, 1, 1, 0, 2, 1, 3);
    // long green
    st("t4 r2", R, 1, 2, 0, 2, 1, 3);
    st("t4 r3", R, 1, 3, 0, 2, 1, 3);
    st("t4 r4", R, 1, 4, 0, 2, 1, 3);
    st("t4 g1", G, 2, 1, 0, 2, 1, 3);
    st("t4 g2", G, 2, 2, 0, 2, 1, 3);
    st("t4 g3", G, 2, 3, 0, 2, 1, 3);
    st("t4 g4", G, 2, 4, 1, 4, 1, 3);
    st("t4 g5", G, 2, 5, 0, 4, 1, 3);
    // illegal codes then resync on a partial green
    st("t5 z1", 3'b000, 0, 0, 1, 1, 1, 3);
    st("t5 z2", 3'b000, 0, 0, 0, 1, 1, 3);
    st("t5 z3", 3'b000, 0, 0, 0, 1, 1, 3);
    st("t5 011", 3'b011, 0, 0, 0, 1, 1, 3);
    st("t5 g1", G, 2, 1, 0, 1, 1, 3);
    st("t5 g2", G, 2, 2, 0, 1, 1, 3);
    st("t5 y1", Y, 3, 1, 0, 1, 1, 3);
    // async reset mid-green
    st("t6 y2", Y, 3, 2, 0, 1, 1, 3);
    st("t6 r1", R, 1, 1, 0, 1, 1, 4);
    st("t6 r2", R, 1, 2, 0, 1, 1, 4);
    st("t6 r3", R, 1, 3, 0, 1, 1, 4);
    st("t6 r4", R, 1, 4, 0, 1, 1, 4);
    st("t6 g1", G, 2, 1, 0, 1, 1, 4);
    #2 reset = 1'b1;
    #1;
    chk_all("t6 async", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("t6 held", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    st("t6 c1", R, 1, 1, 0, 0, 0, 0);
    st("t6 c2", R, 1, 2, 0, 0, 0, 0);
    st("t6 c3", R, 1, 3, 0, 0, 0, 0);
    st("t6 c4", R, 1, 4, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
